// File: rtl/req_ack_sink_fifo.sv
// req_ack_sink_fifo: consumer for a req/ack byte stream. Answers each request
// with ack after a programmable delay, stores every accepted byte in a small
// FIFO and re-presents it on a valid/ready output stream. ack is withheld
// whenever the FIFO could not take the next byte.
module req_ack_sink_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int ACK_DELAY  = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [DATA_WIDTH-1:0]   data,
    output logic                    ack,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_WIDTH-1:0]    xfer_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    // Delay counter preload: DELAY lasts ACK_DELAY-1 posedges before ACK.
    localparam logic [3:0] DCNT_INIT = (ACK_DELAY >= 2) ? 4'(ACK_DELAY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        ACK
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [3:0]             dcnt;
    logic [3:0]             dcnt_next;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_next;
    logic                   push;
    logic                   pop;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    assign push      = (state == ACK) && req;
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Occupancy after this edge; a same-cycle pop makes room for a push.
    always_comb begin
        level_next = level + LVL_W'(push) - LVL_W'(pop);
    end

    // Handshake FSM: only enter or stay in ACK when the next push will fit.
    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        case (state)
            IDLE: begin
                if (req && (level_next < FULL_LEVEL)) begin
                    if (ACK_DELAY == 1) begin
                        state_next = ACK;
                    end else begin
                        state_next = DELAY;
                        dcnt_next  = DCNT_INIT;
                    end
                end
            end
            DELAY: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (dcnt == 4'd0) begin
                    state_next = ACK;
                end else begin
                    dcnt_next = dcnt - 4'd1;
                end
            end
            ACK: begin
                if (!req || (level_next == FULL_LEVEL)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; ack gets its own flop so the BFM sees a clean output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= 4'd0;
            ack   <= 1'b0;
        end else begin
            state <= state_next;
            dcnt  <= dcnt_next;
            ack   <= (state_next == ACK);
        end
    end

    // FIFO bookkeeping: pointers wrap freely, level tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            xfer_count <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                xfer_count <= xfer_count + CNT_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // The FSM must never let a push land on a full FIFO.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) !(push && (level == FULL_LEVEL))
    );

endmodule

// File: tb/tb_req_ack_sink_fifo.sv
// Testbench for req_ack_sink_fifo: a table of vectors plus hand sequences for
// the delay, reset and counter-wrap corners, with a data scoreboard.
module tb_req_ack_sink_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CW    = 4;
    localparam int CW3   = 8;

    logic           clk = 1'b0;
    logic           rst;

    // Main instance: ACK_DELAY=1, 4-bit counter
    logic           req;
    logic [DW-1:0]  data;
    logic           ack;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [LW-1:0]  level;
    logic [CW-1:0]  xfer_count;

    // Second instance: ACK_DELAY=3
    logic           req3;
    logic [DW-1:0]  data3;
    logic           ack3;
    logic           out_valid3;
    logic           out_ready3;
    logic [DW-1:0]  out_data3;
    logic [LW-1:0]  level3;
    logic [CW3-1:0] xfer_count3;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_level  = 0;
    logic [DW-1:0] sb [$];

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          rdy;
        logic          push;
        logic          exp_ack;
        int            exp_level;
        int            exp_count;
    } vec_t;

    vec_t vecs [$];

    req_ack_sink_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACK_DELAY(1), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .xfer_count(xfer_count)
    );

    req_ack_sink_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ACK_DELAY(3), .CNT_WIDTH(CW3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .data(data3), .ack(ack3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .level(level3), .xfer_count(xfer_count3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive main-DUT inputs at a negedge, score pushes/pops, wait one cycle.
    task automatic applyStimulus(input logic r, input logic [DW-1:0] d, input logic rdy, input logic push);
        req       = r;
        data      = d;
        out_ready = rdy;
        if (push) sb.push_back(d);
        if (rdy && (model_level != 0)) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'd1, 32'd0);
            end else begin
                checkOutput("out_data", 32'(out_data), 32'(sb[0]));
                void'(sb.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic addVec(input logic r, input logic [7:0] d, input logic rdy, input logic p,
                          input logic a, input int lv, input int cnt);
        vec_t v;
        v.req = r; v.data = d; v.rdy = rdy; v.push = p;
        v.exp_ack = a; v.exp_level = lv; v.exp_count = cnt;
        vecs.push_back(v);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        req = 1'b0; data = '0; out_ready = 1'b0;
        req3 = 1'b0; data3 = '0; out_ready3 = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst ack", 32'(ack), 32'd0);
        checkOutput("rst valid", 32'(out_valid), 32'd0);
        checkOutput("rst level", 32'(level), 32'd0);
        checkOutput("rst count", 32'(xfer_count), 32'd0);
        checkOutput("rst ack3", 32'(ack3), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ACK_DELAY=3, abandoned request: req dropped after 2 sampled edges
        req3 = 1'b1; data3 = 8'h33;
        @(negedge clk); checkOutput("d3ab e1 ack", 32'(ack3), 32'd0);
        @(negedge clk); checkOutput("d3ab e2 ack", 32'(ack3), 32'd0);
        req3 = 1'b0;
        @(negedge clk); checkOutput("d3ab e3 ack", 32'(ack3), 32'd0);
        @(negedge clk); checkOutput("d3ab e4 ack", 32'(ack3), 32'd0);
        checkOutput("d3ab level", 32'(level3), 32'd0);
        checkOutput("d3ab count", 32'(xfer_count3), 32'd0);

        // ACK_DELAY=3, held request: ack on the third posedge, then one push
        req3 = 1'b1;
        @(negedge clk); checkOutput("d3 e1 ack", 32'(ack3), 32'd0);
        @(negedge clk); checkOutput("d3 e2 ack", 32'(ack3), 32'd0);
        @(negedge clk); checkOutput("d3 e3 ack", 32'(ack3), 32'd1);
        @(negedge clk);
        checkOutput("d3 push level", 32'(level3), 32'd1);
        checkOutput("d3 push count", 32'(xfer_count3), 32'd1);
        checkOutput("d3 out_data", 32'(out_data3), 32'h33);
        req3 = 1'b0; out_ready3 = 1'b1;
        @(negedge clk);
        checkOutput("d3 drop ack", 32'(ack3), 32'd0);
        checkOutput("d3 pop level", 32'(level3), 32'd0);
        checkOutput("d3 pop count", 32'(xfer_count3), 32'd1);
        out_ready3 = 1'b0;

        // Vector table: single transfer, fill to full, drain with overlap
        addVec(1, 8'h5A, 1, 0, 1, 0, 0);
        addVec(1, 8'h5A, 1, 1, 1, 1, 1);
        addVec(0, 8'h00, 1, 0, 0, 0, 1);
        addVec(1, 8'h01, 0, 0, 1, 0, 1);
        addVec(1, 8'h01, 0, 1, 1, 1, 2);
        addVec(1, 8'h02, 0, 1, 1, 2, 3);
        addVec(1, 8'h03, 0, 1, 1, 3, 4);
        addVec(1, 8'h04, 0, 1, 0, 4, 5);
        addVec(1, 8'h05, 0, 0, 0, 4, 5);
        addVec(1, 8'h05, 0, 0, 0, 4, 5);
        addVec(1, 8'h05, 1, 0, 1, 3, 5);
        addVec(1, 8'h05, 1, 1, 1, 3, 6);
        addVec(1, 8'h06, 1, 1, 1, 3, 7);
        addVec(0, 8'h00, 1, 0, 0, 2, 7);
        addVec(0, 8'h00, 1, 0, 0, 1, 7);
        addVec(0, 8'h00, 1, 0, 0, 0, 7);
        addVec(0, 8'h00, 1, 0, 0, 0, 7);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].data, vecs[i].rdy, vecs[i].push);
            checkOutput($sformatf("v%0d ack", i), 32'(ack), 32'(vecs[i].exp_ack));
            checkOutput($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].exp_level));
            checkOutput($sformatf("v%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_level != 0));
            checkOutput($sformatf("v%0d count", i), 32'(xfer_count), 32'(vecs[i].exp_count));
            model_level = vecs[i].exp_level;
        end

        // Reset mid-burst with level=2 and ack high
        applyStimulus(1, 8'hA1, 0, 0);
        applyStimulus(1, 8'hA1, 0, 1);
        applyStimulus(1, 8'hA2, 0, 1);
        checkOutput("burst level", 32'(level), 32'd2);
        checkOutput("burst ack", 32'(ack), 32'd1);
        checkOutput("burst count", 32'(xfer_count), 32'd9);
        rst = 1'b1;
        #1;
        checkOutput("async rst ack", 32'(ack), 32'd0);
        checkOutput("async rst valid", 32'(out_valid), 32'd0);
        checkOutput("async rst level", 32'(level), 32'd0);
        checkOutput("async rst count", 32'(xfer_count), 32'd0);
        sb.delete();
        model_level = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post rst ack", 32'(ack), 32'd0);
        @(negedge clk);
        checkOutput("post rst reack", 32'(ack), 32'd1);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("post rst drop ack", 32'(ack), 32'd0);
        checkOutput("post rst level", 32'(level), 32'd0);

        // Counter wrap with a 4-bit counter: 17 back-to-back transfers
        applyStimulus(1, 8'h10, 1, 0);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1, 8'(8'h10 + k), 1, 1);
            model_level = 1;
            checkOutput($sformatf("wrap k%0d count", k), 32'(xfer_count), 32'(k % 16));
            checkOutput($sformatf("wrap k%0d ack", k), 32'(ack), 32'd1);
        end
        applyStimulus(0, 8'h00, 1, 0);
        model_level = 0;
        checkOutput("wrap drain level", 32'(level), 32'd0);
        checkOutput("wrap final count", 32'(xfer_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
